// File: rtl/led_pattern_gen.sv
// LED bank pattern generator: TOGGLE / BOUNCE / COUNT / DIM modes with a programmable step rate.
// Outputs are registered; a mode change reseeds the pattern on the edge that samples it.
module led_pattern_gen #(
  parameter int          CLK_FREQ    = 25_000_000,
  parameter int          STEP_DIV    = 2,
  parameter int          N_LEDS      = 8,
  parameter logic [31:0] TOGGLE_MASK = 32'h5555_5555,
  parameter int          PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                pause,
  input  logic [PWM_BITS-1:0] duty,
  output logic [N_LEDS-1:0]   leds,
  output logic                step_pulse
);

  localparam int STEP_CYCLES = CLK_FREQ / STEP_DIV;
  localparam int CNT_W       = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STEP_CYCLES - 1);
  localparam logic [N_LEDS-1:0] MASK    = TOGGLE_MASK[N_LEDS-1:0];
  localparam logic [N_LEDS-1:0] ONES    = '1;
  localparam logic [N_LEDS-1:0] SEED1   = N_LEDS'(1);

  typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;
  typedef enum logic [1:0] {MODE_TOGGLE, MODE_BOUNCE, MODE_COUNT, MODE_DIM} mode_e;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  mode_e               mode_q, mode_d;
  dir_e                dir_q, dir_d;
  logic [N_LEDS-1:0]   pat_q, pat_d;
  logic [N_LEDS-1:0]   leds_q, leds_d;
  logic                step_pulse_q, step_pulse_d;
  logic [N_LEDS-1:0]   shifted;

  always_comb begin
    cnt_d        = cnt_q;
    pwm_cnt_d    = pwm_cnt_q + PWM_BITS'(1);
    mode_d       = mode_q;
    dir_d        = dir_q;
    pat_d        = pat_q;
    step_pulse_d = 1'b0;
    shifted      = (dir_q == DIR_LEFT) ? (pat_q << 1) : (pat_q >> 1);

    // Mode change outranks both pause and a coincident terminal count.
    if (mode != mode_q) begin
      mode_d = mode_e'(mode);
      cnt_d  = '0;
      dir_d  = DIR_LEFT;
      case (mode_e'(mode))
        MODE_COUNT: pat_d = '0;
        MODE_DIM:   pat_d = ONES;
        default:    pat_d = SEED1;
      endcase
    end else if (!pause) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d        = '0;
        step_pulse_d = 1'b1;
        case (mode_q)
          MODE_TOGGLE: pat_d = pat_q ^ MASK;
          MODE_BOUNCE: begin
            pat_d = shifted;
            if (dir_q == DIR_LEFT && shifted[N_LEDS-1]) dir_d = DIR_RIGHT;
            if (dir_q == DIR_RIGHT && shifted[0])       dir_d = DIR_LEFT;
          end
          MODE_COUNT:  pat_d = pat_q + N_LEDS'(1);
          default:     pat_d = ONES;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // DIM compares the current pwm count, so leds trails pwm_cnt by one cycle.
    if (mode_d == MODE_DIM) leds_d = (pwm_cnt_q < duty) ? ONES : '0;
    else                    leds_d = pat_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      pwm_cnt_q    <= '0;
      mode_q       <= MODE_TOGGLE;
      dir_q        <= DIR_LEFT;
      pat_q        <= SEED1;
      leds_q       <= SEED1;
      step_pulse_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      pat_q        <= pat_d;
      leds_q       <= leds_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign leds       = leds_q;
  assign step_pulse = step_pulse_q;

endmodule
